// File: rtl/sraml_resp_mem.sv
// sram-like responder backed by an on-chip word memory: in-order, fixed latency, bounded outstanding.
// Define SRAML_RESP_STALL_EN to add LFSR-driven random address-phase backpressure.
module sraml_resp_mem #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);
   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned IDX_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned PTR_W = $clog2(OUTSTANDING) + 1;
   localparam int unsigned AGE_W = 4;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

   typedef struct packed {
      logic              wr;
      logic [1:0]        size;
      logic [ADDR_W+1:0] addr;
      logic [31:0]       wdata;
   } entry_t;

   logic [31:0]        mem_q [DEPTH];
   entry_t             ent_q [OUTSTANDING];
   logic [AGE_W-1:0]   age_q [OUTSTANDING];
   logic [AGE_W-1:0]   age_d [OUTSTANDING];
   logic [OUTSTANDING-1:0] vld_q, vld_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

   logic [IDX_W-1:0]   wr_idx, rd_idx;
   logic               full, push, pop, commit, stall;
   entry_t             head;
   logic [3:0]         be;
   logic [ADDR_W-1:0]  widx;

   // Upper address bits alias the memory and are deliberately dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef SRAML_RESP_STALL_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 8'hA5;
      else     lfsr_q <= lfsr_d;
   end

   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   // Handshake, completion and read-data decode from the queue head.
   always_comb begin
      wr_idx  = IDX_W'(wr_ptr_q % PTR_W'(OUTSTANDING));
      rd_idx  = IDX_W'(rd_ptr_q % PTR_W'(OUTSTANDING));
      full    = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
      head    = ent_q[rd_idx];
      data_ok = vld_q[rd_idx] && (age_q[rd_idx] == AGE_MAX);
      pop     = data_ok;
      addr_ok = req && (!full || pop) && !stall;
      push    = addr_ok;
      commit  = pop && head.wr;
      widx    = head.addr[ADDR_W+1:2];
      rdata   = (data_ok && !head.wr) ? mem_q[widx] : 32'h0;
      case (head.size)
         2'd0:    be = 4'b0001 << head.addr[1:0];
         2'd1:    be = head.addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Queue bookkeeping; a push into the slot being popped wins that slot.
   always_comb begin
      vld_d    = vld_q;
      age_d    = age_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      for (int i = 0; i < OUTSTANDING; i++) begin
         if (vld_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + AGE_W'(1);
      end
      if (pop) vld_d[rd_idx] = 1'b0;
      if (push) begin
         vld_d[wr_idx] = 1'b1;
         age_d[wr_idx] = AGE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
         for (int i = 0; i < OUTSTANDING; i++) age_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
         for (int i = 0; i < OUTSTANDING; i++) age_q[i] <= age_d[i];
      end
   end

   // Payload storage and memory array are not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_q[wr_idx] <= '{wr: wr, size: size, addr: addr[ADDR_W+1:0], wdata: wdata};
      end
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[widx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end

endmodule
